// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO, sending each word as a UART frame (start, LSB-first data, [even parity], stop).
// Latency: pop strobe and start bit appear on the edge after a word is seen in IDLE; frame = (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: pops only in IDLE with i_enable && !i_empty; define LIBSV_FIFO_UART_TX_PARITY_EN for the even-parity bit.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  i_clock,
    input  logic                  i_areset,
    input  logic                  i_enable,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_rd_en,
    output logic                  o_tx,
    output logic                  o_busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic                    tx_q, tx_d;
    logic                    baud_tick;
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    assign baud_tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The head word is captured on the same edge the pop strobe rises,
                // so the FIFO pop one cycle later cannot disturb it.
                if (i_enable && !i_empty) begin
                    shift_d = i_data;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_START;
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_q == DATA_LAST) begin
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // The bit counter is reused to count stop bits.
                if (baud_tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            bit_d = '0;
        end

        if ((state_d != state_q) || (state_q == S_IDLE) || baud_tick) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        // Line level is registered from the state being entered so it changes on the transition edge.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign o_rd_en = rd_en_q;
    assign o_tx    = tx_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeding the DUT, UART line decoder feeding a frame scoreboard.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
    localparam int PB = 1;
    localparam int SB = 2;
`else
    localparam int PB = 0;
    localparam int SB = 1;
`endif
    localparam int NB    = 1 + DW + PB + SB;
    localparam int FRAME = NB * CPB;

    typedef struct {
        logic [DW-1:0] data;
        logic          fmt_ok;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          o_rd_en, o_tx, o_busy;
    logic [DW-1:0] fifo_mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            pop_cnt = 0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;

    logic [DW-1:0] exp_q [$];
    frame_t        got_q [$];
    int            checks = 0;
    int            passes = 0;

    logic [15:0]   mon_bits;
    int            mon_idx = 0;
    logic          mon_act = 1'b0;
    bit            rd_on_empty = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_head  = fifo_mem[rd_ptr % 64];

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .i_clock (clk),
        .i_areset(rst),
        .i_enable(en),
        .i_empty (fifo_empty),
        .i_data  (fifo_head),
        .o_rd_en (o_rd_en),
        .o_tx    (o_tx),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    // FIFO pops on the edge that ends the strobe cycle.
    always @(posedge clk) begin
        if (o_rd_en) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Line decoder: samples each bit mid-period and hands finished frames to the scoreboard.
    always @(negedge clk) begin
        frame_t fr;
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (o_rd_en && fifo_empty) rd_on_empty = 1'b1;
            if (!mon_act && o_tx == 1'b0) begin
                mon_act = 1'b1;
                mon_idx = 0;
            end else if (mon_act) begin
                mon_idx = mon_idx + 1;
            end
            if (mon_act) begin
                if (mon_idx % CPB == CPB / 2) mon_bits[mon_idx / CPB] = o_tx;
                if (mon_idx == FRAME - 1) begin
                    mon_act   = 1'b0;
                    fr.data   = mon_bits[DW:1];
                    fr.fmt_ok = (mon_bits[0] == 1'b0);
                    for (int s = 0; s < SB; s++)
                        if (mon_bits[1 + DW + PB + s] !== 1'b1) fr.fmt_ok = 1'b0;
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
                    if (mon_bits[DW + 1] !== ^mon_bits[DW:1]) fr.fmt_ok = 1'b0;
`endif
                    got_q.push_back(fr);
                end
            end
        end
    end

    task automatic push(input logic [DW-1:0] w, input bit expect_out);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_tx, o_rd_en, o_busy} !== 3'b100)
            $display("FAIL reset_outputs: tx/rd_en/busy=%b expected 100", {o_tx, o_rd_en, o_busy});
        else passes++;
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({o_tx, o_rd_en, o_busy} !== 3'b100)
                $display("FAIL idle_empty cycle %0d: tx/rd_en/busy=%b expected 100", k, {o_tx, o_rd_en, o_busy});
            else passes++;
        end
    endtask

    task automatic test_single(input logic [DW-1:0] w);
        logic [15:0] seq;
        int          busy_cyc = 0;
        int          pops0 = pop_cnt;
        frame_t      f;
        logic [DW-1:0] e;
        seq = '1;
        seq[0] = 1'b0;
        seq[DW:1] = w;
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
        seq[DW + 1] = ^w;
`endif
        push(w, 1'b1);
        for (int k = 1; k <= FRAME + 2; k++) begin
            logic [2:0] want;
            @(negedge clk);
            want = {(k <= FRAME) ? seq[(k - 1) / CPB] : 1'b1, (k <= FRAME), (k == 1)};
            if (o_busy) busy_cyc++;
            checks++;
            if ({o_tx, o_busy, o_rd_en} !== want)
                $display("FAIL single_cycle %0d: tx/busy/rd_en=%b expected %b", k, {o_tx, o_busy, o_rd_en}, want);
            else passes++;
        end
        checks++;
        if (busy_cyc != FRAME) $display("FAIL single_busy_len: %0d cycles expected %0d", busy_cyc, FRAME);
        else passes++;
        checks++;
        if (pop_cnt - pops0 != 1 || fifo_empty !== 1'b1)
            $display("FAIL single_pops: pops=%0d empty=%b expected 1 and 1", pop_cnt - pops0, fifo_empty);
        else passes++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (f.data !== e || f.fmt_ok !== 1'b1)
                $display("FAIL single_frame: data=%h fmt=%b expected %h fmt=1", f.data, f.fmt_ok, e);
            else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0)
            $display("FAIL single_leftover: exp=%0d got=%0d expected 0 0", exp_q.size(), got_q.size());
        else passes++;
    endtask

    task automatic test_back_to_back();
        int     pops0 = pop_cnt;
        int     rd_cyc = 0;
        frame_t f;
        logic [DW-1:0] e;
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        for (int k = 1; k <= 2 * FRAME + 3; k++) begin
            @(negedge clk);
            if (o_rd_en) rd_cyc++;
            if (k == FRAME + 1) begin
                checks++;
                if ({o_tx, o_busy, o_rd_en} !== 3'b100)
                    $display("FAIL b2b_gap: tx/busy/rd_en=%b expected 100", {o_tx, o_busy, o_rd_en});
                else passes++;
            end
            if (k == FRAME + 2) begin
                checks++;
                if ({o_tx, o_busy, o_rd_en} !== 3'b011)
                    $display("FAIL b2b_second_start: tx/busy/rd_en=%b expected 011", {o_tx, o_busy, o_rd_en});
                else passes++;
            end
        end
        checks++;
        if (rd_cyc != 2 || pop_cnt - pops0 != 2 || fifo_empty !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL b2b_drain: strobes=%0d pops=%0d empty=%b busy=%b expected 2 2 1 0",
                     rd_cyc, pop_cnt - pops0, fifo_empty, o_busy);
        else passes++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (f.data !== e || f.fmt_ok !== 1'b1)
                $display("FAIL b2b_frame: data=%h fmt=%b expected %h fmt=1", f.data, f.fmt_ok, e);
            else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0)
            $display("FAIL b2b_leftover: exp=%0d got=%0d expected 0 0", exp_q.size(), got_q.size());
        else passes++;
    endtask

    task automatic test_enable_drop();
        int     pops0 = pop_cnt;
        int     rd_cyc = 0;
        frame_t f;
        logic [DW-1:0] e;
        push(8'h5A, 1'b1);
        push(8'h81, 1'b1);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) $display("FAIL drop_launch: busy=%b expected 1", o_busy);
        else passes++;
        repeat (11) @(negedge clk);
        en = 1'b0;
        repeat (FRAME + 20) begin
            @(negedge clk);
            if (o_rd_en) rd_cyc++;
        end
        checks++;
        if (rd_cyc != 0 || pop_cnt - pops0 != 1 || fifo_empty !== 1'b0 || {o_tx, o_busy} !== 2'b10)
            $display("FAIL drop_hold: strobes=%0d pops=%0d empty=%b tx/busy=%b expected 0 1 0 10",
                     rd_cyc, pop_cnt - pops0, fifo_empty, {o_tx, o_busy});
        else passes++;
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_tx, o_busy, o_rd_en} !== 3'b011)
            $display("FAIL drop_resume: tx/busy/rd_en=%b expected 011", {o_tx, o_busy, o_rd_en});
        else passes++;
        repeat (FRAME + 2) @(negedge clk);
        checks++;
        if (pop_cnt - pops0 != 2 || o_busy !== 1'b0)
            $display("FAIL drop_end: pops=%0d busy=%b expected 2 0", pop_cnt - pops0, o_busy);
        else passes++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (f.data !== e || f.fmt_ok !== 1'b1)
                $display("FAIL drop_frame: data=%h fmt=%b expected %h fmt=1", f.data, f.fmt_ok, e);
            else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0)
            $display("FAIL drop_leftover: exp=%0d got=%0d expected 0 0", exp_q.size(), got_q.size());
        else passes++;
    endtask

    task automatic test_reset_abort();
        int     pops0 = pop_cnt;
        frame_t f;
        logic [DW-1:0] e;
        push(8'h3C, 1'b0);
        push(8'hC3, 1'b1);
        @(negedge clk);
        // Move into the middle of data bit 3.
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_tx, o_busy, o_rd_en} !== 3'b100)
            $display("FAIL abort_async: tx/busy/rd_en=%b expected 100", {o_tx, o_busy, o_rd_en});
        else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 4) @(negedge clk);
        checks++;
        if (pop_cnt - pops0 != 2 || fifo_empty !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL abort_pops: pops=%0d empty=%b busy=%b expected 2 1 0", pop_cnt - pops0, fifo_empty, o_busy);
        else passes++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (f.data !== e || f.fmt_ok !== 1'b1)
                $display("FAIL abort_frame: data=%h fmt=%b expected %h fmt=1", f.data, f.fmt_ok, e);
            else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0)
            $display("FAIL abort_leftover: exp=%0d got=%0d expected 0 0", exp_q.size(), got_q.size());
        else passes++;
        checks++;
        if (rd_on_empty !== 1'b0) $display("FAIL rd_en_on_empty: seen=%b expected 0", rd_on_empty);
        else passes++;
    endtask

`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        int     busy_cyc = 0;
        int     stop_cyc = 0;
        frame_t f;
        logic [DW-1:0] e;
        push(8'h07, 1'b1);
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            if (o_busy) busy_cyc++;
            if (k > 36 && k <= 40) begin
                checks++;
                if (o_tx !== 1'b1) $display("FAIL parity_bit cycle %0d: tx=%b expected 1", k, o_tx);
                else passes++;
            end
            if (k > 40 && k <= 48 && o_tx === 1'b1) stop_cyc++;
        end
        checks++;
        if (busy_cyc != 48 || stop_cyc != 8)
            $display("FAIL parity_len: busy=%0d stop=%0d expected 48 8", busy_cyc, stop_cyc);
        else passes++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (f.data !== e || f.fmt_ok !== 1'b1)
                $display("FAIL parity_frame: data=%h fmt=%b expected %h fmt=1", f.data, f.fmt_ok, e);
            else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0)
            $display("FAIL parity_leftover: exp=%0d got=%0d expected 0 0", exp_q.size(), got_q.size());
        else passes++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'h3E);
        test_back_to_back();
        test_enable_drop();
        test_reset_abort();
`ifdef LIBSV_FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
